quadrature_input_filter: RTL and testbench
==========================================

// Module: quadrature_input_filter
// PURPOSE
//  Conditions the raw A/B quadrature pins of one joint encoder before they reach the position counter.
//  Synchronises both pins to CLK and rejects glitches/bounce with a per-channel persistence filter.
//  Decodes the clean signals into a one-cycle step pulse, a direction bit and a sticky illegal-transition flag.
//  One instance per encoder, between the FPGA pins and the encoder counter stage.
// PARAMETERS
//  FILTER_CYCLES  16  consecutive CLK cycles a new synced level must persist before it is accepted (>=2)
//  FILTER_W       5   filter counter width; must hold FILTER_CYCLES-1 and STARTUP_CYCLES
//  X4_MODE        1   1: step on every valid transition (x4); 0: step only on valid transitions where A_clean changes (x2)
// PORTS
//  CLK      in   1  system clock, all state on rising edge
//  RST_N    in   1  asynchronous active-low reset
//  A        in   1  raw encoder channel A, asynchronous to CLK
//  B        in   1  raw encoder channel B, asynchronous to CLK
//  ERR_CLR  in   1  synchronous clear of err
//  A_clean  out  1  filtered channel A
//  B_clean  out  1  filtered channel B
//  step     out  1  one-cycle pulse per accepted quadrature transition
//  dir      out  1  1 = CW, 0 = CCW; direction of the last valid transition
//  err      out  1  sticky illegal-transition flag
// BEHAVIOUR
//  Reset (RST_N=0, async):
//   - Sync flops, filter counters, A_clean, B_clean, prev-state, step, dir and err all go to 0.
//   - The startup counter also goes to 0.
//   - Reset asserted mid-operation aborts any filter count in progress; no pulse is produced.
//  Synchroniser: 2-FF chain per channel (A_s1->A_s2, B_s1->B_s2), reset to 0.
//  Filter, per channel, each edge:
//   - If X_s2 == X_clean: cnt <= 0.
//   - Else if cnt == FILTER_CYCLES-1: X_clean <= X_s2 and cnt <= 0.
//   - Else: cnt <= cnt+1.
//   - Pin change stable before edge 0 gives X_clean updated at edge 2+FILTER_CYCLES.
//   - Any bounce back to the clean level restarts the count.
//  Decoder:
//   - prev <= {A_clean,B_clean} every cycle.
//   - cur = {A_clean,B_clean}; evaluated when cur != prev.
//   - CW (dir=1) sequence: 00->01->11->10->00.
//   - CCW (dir=0) sequence: reverse of CW.
//   - Valid transition (exactly one bit differs): dir <= direction.
//   - step <= 1 for exactly one cycle, one cycle after the clean change.
//   - With X4_MODE=0, step is raised only when the A bit changed; dir still updates.
//   - Illegal transition (both bits differ in one cycle): err <= 1; step stays 0; dir holds.
//   - cur == prev: step <= 0, dir/err hold.
//  Startup blanking:
//   - Startup counter counts 0..STARTUP_CYCLES, where STARTUP_CYCLES = FILTER_CYCLES+3, then saturates.
//   - While not saturated, the decoder updates prev but produces no step and does not set err.
//   - This absorbs the initial pin levels, e.g. encoder parked at 11.
//  err:
//   - Sticky until ERR_CLR=1 (synchronous clear).
//   - If ERR_CLR and a new illegal transition occur in the same cycle, set wins (err stays 1).
//  Rate limit: transitions closer than FILTER_CYCLES+1 cycles apart may merge and flag err; this is required behaviour.
// TESTING
//  1. Reset, pins 00, CW sequence 00->01->11->10->00 with 40 cycles per state:
//     4 step pulses, each 1 cycle wide, dir=1, err=0.
//     First B_clean rise 18 cycles after the B change.
//  2. Same sequence reversed (CCW): 4 steps, dir=0.
//     Repeat with X4_MODE=0: 2 steps, only on the A edges.
//  3. Glitch rejection: A pulses high for 15 cycles, low 3, high 15:
//     A_clean stays 0, no step.
//     A held 16 cycles: A_clean rises.
//  4. A and B toggle in the same cycle (00->11), held 40 cycles:
//     err=1, no step, dir unchanged.
//     ERR_CLR for 1 cycle: err=0.
//     Illegal transition coincident with ERR_CLR: err stays 1.
//  5. Release reset with pins at 11:
//     A_clean/B_clean reach 1 at cycle 18, no err and no step.
//     Next valid transition 11->10 produces step with dir=1.
//  6. Assert RST_N low mid-count (A changed 10 cycles earlier):
//     all outputs 0 immediately.
//     After release, behaviour matches a clean reset (scenario 5 timing).

Source files
------------

// File: rtl/quadrature_input_filter.sv
// Synchronises and persistence-filters encoder A/B pins, then decodes step/dir/illegal-transition.
// Latency: pin to clean level in 2+FILTER_CYCLES clocks, step one clock later; no backpressure, step is a bare pulse.
module quadrature_input_filter #(
    parameter int FILTER_CYCLES = 16,
    parameter int FILTER_W      = 5,
    parameter bit X4_MODE       = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic A,
    input  logic B,
    input  logic ERR_CLR,
    output logic A_clean,
    output logic B_clean,
    output logic step,
    output logic dir,
    output logic err
);

    localparam int STARTUP_CYCLES = FILTER_CYCLES + 3;
    localparam logic [FILTER_W-1:0] CNT_LAST     = FILTER_W'(FILTER_CYCLES - 1);
    localparam logic [FILTER_W-1:0] STARTUP_LAST = FILTER_W'(STARTUP_CYCLES);

    // Bit 1 carries channel A, bit 0 channel B throughout.
    logic [1:0]          s1_q, s1_d;
    logic [1:0]          s2_q, s2_d;
    logic [1:0]          clean_q, clean_d;
    logic [1:0]          prev_q, prev_d;
    logic [FILTER_W-1:0] cnt_q [2];
    logic [FILTER_W-1:0] cnt_d [2];
    logic [FILTER_W-1:0] startup_q, startup_d;
    logic                step_q, step_d;
    logic                dir_q, dir_d;
    logic                err_q, err_d;
    logic [1:0]          chg;
    logic                blank;

    always_comb begin
        s1_d = {A, B};
        s2_d = s1_q;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i]   = '0;
            clean_d[i] = clean_q[i];
            if (s2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        chg       = clean_q ^ prev_q;
        blank     = (startup_q != STARTUP_LAST);
        startup_d = blank ? startup_q + 1'b1 : startup_q;
        prev_d    = clean_q;
        step_d    = 1'b0;
        dir_d     = dir_q;
        err_d     = err_q & ~ERR_CLR;
        // Blanking swallows whatever the pins were parked at when reset released.
        if (!blank) begin
            case (chg)
                2'b11: err_d = 1'b1;
                2'b10, 2'b01: begin
                    // CW successor of {a,b} is {b,~a}: 00->01->11->10->00.
                    dir_d  = (clean_q == {prev_q[0], ~prev_q[1]});
                    step_d = X4_MODE || chg[1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q      <= '0;
            s2_q      <= '0;
            clean_q   <= '0;
            prev_q    <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            startup_q <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            clean_q   <= clean_d;
            prev_q    <= prev_d;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
            startup_q <= startup_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
        end
    end

    assign A_clean = clean_q[1];
    assign B_clean = clean_q[0];
    assign step    = step_q;
    assign dir     = dir_q;
    assign err     = err_q;

endmodule

// File: tb/tb_quadrature_input_filter.sv
// Bench for quadrature_input_filter: x4 and x2 instances share the pins; steps checked against a timed queue.
module tb_quadrature_input_filter;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    logic A = 1'b0;
    logic B = 1'b0;
    logic ERR_CLR = 1'b0;
    logic a4, b4, step4, dir4, err4;
    logic a2, b2, step2, dir2, err2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] ab;
        logic       clr;
        int         hold;
        logic [1:0] exp_clean;
        logic       exp_dir;
        logic       exp_err;
    } vec_t;

    typedef struct {
        int   cyc;
        logic dir;
    } ev_t;

    vec_t       vecs [19];
    ev_t        q4 [$];
    ev_t        q2 [$];
    ev_t        ev4, ev2;
    logic [1:0] model_ab = 2'b00;

    quadrature_input_filter #(.FILTER_CYCLES(16), .FILTER_W(5), .X4_MODE(1'b1)) dut_x4 (
        .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .ERR_CLR(ERR_CLR),
        .A_clean(a4), .B_clean(b4), .step(step4), .dir(dir4), .err(err4)
    );

    quadrature_input_filter #(.FILTER_CYCLES(16), .FILTER_W(5), .X4_MODE(1'b0)) dut_x2 (
        .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .ERR_CLR(ERR_CLR),
        .A_clean(a2), .B_clean(b2), .step(step2), .dir(dir2), .err(err2)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic is_cw(input logic [1:0] from, input logic [1:0] to);
        case ({from, to})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge CLK) begin
        if (step4 === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL step_x4_unexpected: got step at cycle %0d expected none", cyc);
            end else begin
                ev4 = q4.pop_front();
                checks--;
                chk("step_x4_cycle", cyc, ev4.cyc);
                chk("step_x4_dir", dir4, ev4.dir);
            end
        end
    end

    always @(negedge CLK) begin
        if (step2 === 1'b1) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL step_x2_unexpected: got step at cycle %0d expected none", cyc);
            end else begin
                ev2 = q2.pop_front();
                checks--;
                chk("step_x2_cycle", cyc, ev2.cyc);
                chk("step_x2_dir", dir2, ev2.dir);
            end
        end
    end

    // Called at a falling edge; the new pin level is first sampled by the next rising edge.
    task automatic apply(input vec_t v, input int idx);
        logic [1:0] old;
        logic       acc;
        int         c;
        old = model_ab;
        c = cyc;
        {A, B} = v.ab;
        ERR_CLR = v.clr;
        acc = (v.ab != old) && (v.hold >= 16);
        if (acc) begin
            if ((v.ab ^ old) != 2'b11) begin
                q4.push_back('{c + 19, is_cw(old, v.ab)});
                if (v.ab[1] != old[1]) q2.push_back('{c + 19, is_cw(old, v.ab)});
            end
            model_ab = v.ab;
        end
        for (int k = 1; k <= v.hold; k++) begin
            @(negedge CLK);
            ERR_CLR = 1'b0;
            if (acc && k == 17) chk($sformatf("v%0d_clean_before", idx), {a4, b4}, old);
            if (acc && k == 18) chk($sformatf("v%0d_clean_at18", idx), {a4, b4}, v.ab);
        end
        chk($sformatf("v%0d_clean_x4", idx), {a4, b4}, v.exp_clean);
        chk($sformatf("v%0d_clean_x2", idx), {a2, b2}, v.exp_clean);
        chk($sformatf("v%0d_dir_x4", idx), dir4, v.exp_dir);
        chk($sformatf("v%0d_dir_x2", idx), dir2, v.exp_dir);
        chk($sformatf("v%0d_err_x4", idx), err4, v.exp_err);
        chk($sformatf("v%0d_err_x2", idx), err2, v.exp_err);
    endtask

    task automatic do_reset(input logic [1:0] p, input string tag);
        int c;
        @(negedge CLK);
        {A, B} = p;
        RST_N = 1'b0;
        #1;
        chk({tag, "_rst_clean"}, {a4, b4}, 2'b00);
        chk({tag, "_rst_step"}, step4, 1'b0);
        chk({tag, "_rst_dir"}, dir4, 1'b0);
        chk({tag, "_rst_err"}, err4, 1'b0);
        chk({tag, "_rst_x2"}, {a2, b2, step2, dir2, err2}, 5'b0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        model_ab = p;
        c = cyc;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (p != 2'b00 && k == 17) chk({tag, "_clean_before"}, {a4, b4}, 2'b00);
            if (p != 2'b00 && k == 18) chk({tag, "_clean_at18"}, {a4, b4}, p);
        end
        chk({tag, "_startup_err"}, {err4, err2}, 2'b00);
        chk({tag, "_startup_clean"}, {a4, b4}, p);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // CW, then CCW, then illegal jumps with clears, then glitch rejection.
        vecs[0]  = '{2'b01, 1'b0, 40, 2'b01, 1'b1, 1'b0};
        vecs[1]  = '{2'b11, 1'b0, 40, 2'b11, 1'b1, 1'b0};
        vecs[2]  = '{2'b10, 1'b0, 40, 2'b10, 1'b1, 1'b0};
        vecs[3]  = '{2'b00, 1'b0, 40, 2'b00, 1'b1, 1'b0};
        vecs[4]  = '{2'b10, 1'b0, 40, 2'b10, 1'b0, 1'b0};
        vecs[5]  = '{2'b11, 1'b0, 40, 2'b11, 1'b0, 1'b0};
        vecs[6]  = '{2'b01, 1'b0, 40, 2'b01, 1'b0, 1'b0};
        vecs[7]  = '{2'b00, 1'b0, 40, 2'b00, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 1'b0, 40, 2'b11, 1'b0, 1'b1};
        vecs[9]  = '{2'b11, 1'b1,  5, 2'b11, 1'b0, 1'b0};
        vecs[10] = '{2'b00, 1'b0, 40, 2'b00, 1'b0, 1'b1};
        vecs[11] = '{2'b00, 1'b1,  3, 2'b00, 1'b0, 1'b0};
        vecs[12] = '{2'b10, 1'b0, 15, 2'b00, 1'b0, 1'b0};
        vecs[13] = '{2'b00, 1'b0,  3, 2'b00, 1'b0, 1'b0};
        vecs[14] = '{2'b10, 1'b0, 15, 2'b00, 1'b0, 1'b0};
        vecs[15] = '{2'b00, 1'b0, 30, 2'b00, 1'b0, 1'b0};
        vecs[16] = '{2'b10, 1'b0, 16, 2'b00, 1'b0, 1'b0};
        vecs[17] = '{2'b10, 1'b0, 40, 2'b10, 1'b0, 1'b0};
        vecs[18] = '{2'b00, 1'b0, 40, 2'b00, 1'b1, 1'b0};

        do_reset(2'b00, "rst00");
        for (int i = 0; i < 19; i++) apply(vecs[i], i);

        // Illegal 00->11 decoded on the same edge that ERR_CLR is high: set must win.
        {A, B} = 2'b11;
        model_ab = 2'b11;
        repeat (18) @(negedge CLK);
        chk("coinc_err_before", err4, 1'b0);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        chk("coinc_err_set_wins_x4", err4, 1'b1);
        chk("coinc_err_set_wins_x2", err2, 1'b1);
        chk("coinc_dir_hold", dir4, 1'b1);
        repeat (21) @(negedge CLK);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        chk("coinc_err_cleared", err4, 1'b0);

        do_reset(2'b11, "park11");
        v = '{2'b10, 1'b0, 40, 2'b10, 1'b1, 1'b0};
        apply(v, 100);

        // Reset lands mid-count: the pending 10->00 change must vanish without a step.
        {A, B} = 2'b00;
        repeat (10) @(negedge CLK);
        do_reset(2'b11, "midrst");
        v = '{2'b01, 1'b0, 40, 2'b01, 1'b0, 1'b0};
        apply(v, 101);

        repeat (5) @(negedge CLK);
        chk("pending_steps_x4", q4.size(), 0);
        chk("pending_steps_x2", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
